// File: rtl/condlogic.sv
// Conditional-execution unit: gates PC/register/memory writes on Cond vs stored flags; the flag and CondExReg state updates land one cycle later.
// No backpressure; en=0 is a bubble that blocks every write and holds all state.
module condlogic (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       CondExReg,
  output logic [3:0] Flags
);

  logic n, z, c, v;
  logic fire;

  assign {n, z, c, v} = Flags;

  // The condition is evaluated against the stored flags only; the current
  // ALU result is never bypassed, so the instruction sees older flags.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

  assign fire     = en & CondEx;
  assign PCSrc    = PCS & fire;
  assign RegWrite = RegW & ~NoWrite & fire;
  assign MemWrite = MemW & fire;

  // N,Z and C,V are written as independent halves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags     <= 4'b0000;
      CondExReg <= 1'b0;
    end else if (en) begin
      CondExReg <= CondEx;
      if (CondEx && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (CondEx && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_condlogic.sv
// Directed self-checking bench for condlogic.
module tb_condlogic;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx, CondExReg;
  logic [3:0] Flags;

  int n_assert = 0;
  int n_fail   = 0;

  condlogic dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .CondExReg(CondExReg),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply a full instruction, then let the combinational outputs settle.
  task automatic drive(input logic e, input logic [3:0] cd, input logic [3:0] alu,
                       input logic [1:0] fw, input logic p, input logic r,
                       input logic m, input logic nw);
    en = e; Cond = cd; ALUFlags = alu; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_tab;

    reset_n = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_cxreg", {3'b0, CondExReg}, 4'b0000);
    chk("rst_eq_condex", {3'b0, CondEx}, 4'b0000);
    tick();
    tick();
    reset_n = 1'b1;

    // After reset: EQ fails, NE passes with Flags=0000
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("eq_condex", {3'b0, CondEx}, 4'b0000);
    chk("eq_pcsrc", {3'b0, PCSrc}, 4'b0000);
    drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ne_condex", {3'b0, CondEx}, 4'b0001);
    chk("ne_pcsrc", {3'b0, PCSrc}, 4'b0001);
    tick();
    chk("ne_cxreg", {3'b0, CondExReg}, 4'b0001);

    // CMP: always, writes all flags, register write suppressed
    drive(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
    chk("cmp_preedge_flags", Flags, 4'b0000);
    tick();
    chk("cmp_flags", Flags, 4'b0110);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cmp_eq_condex", {3'b0, CondEx}, 4'b0001);
    chk("eq_regwrite", {3'b0, RegWrite}, 4'b0001);

    // Independent halves
    drive(1'b1, 4'b1110, 4'b1001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fw01_flags", Flags, 4'b0101);
    drive(1'b1, 4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fw10_flags", Flags, 4'b1001);

    // Failed NE suppresses memory and flag writes
    drive(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_0100", Flags, 4'b0100);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("eq_memwrite", {3'b0, MemWrite}, 4'b0001);
    drive(1'b1, 4'b0001, 4'b1011, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ne_fail_memwrite", {3'b0, MemWrite}, 4'b0000);
    chk("ne_fail_pcsrc", {3'b0, PCSrc}, 4'b0000);
    chk("ne_fail_regwrite", {3'b0, RegWrite}, 4'b0000);
    tick();
    chk("ne_fail_flags", Flags, 4'b0100);
    chk("ne_fail_cxreg", {3'b0, CondExReg}, 4'b0000);

    // No bypass: EQ passes on old Z even though it clears Z
    drive(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nobypass_pre", {3'b0, CondEx}, 4'b0001);
    tick();
    chk("nobypass_flags", Flags, 4'b0000);
    chk("nobypass_post", {3'b0, CondEx}, 4'b0000);

    // Full condition table for Flags=1000 then 1001 (bit i = Cond i)
    drive(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_1000", Flags, 4'b1000);
    exp_tab = 16'h6A9A;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tab1000_c%0d", i), {3'b0, CondEx}, {3'b0, exp_tab[i]});
    end
    drive(1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_1001", Flags, 4'b1001);
    exp_tab = 16'h565A;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tab1001_c%0d", i), {3'b0, CondEx}, {3'b0, exp_tab[i]});
    end

    // en=0 bubbles: no writes, state held
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("al_cxreg", {3'b0, CondExReg}, 4'b0001);
    drive(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("bubble_outs", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    chk("bubble_condex", {3'b0, CondEx}, 4'b0001);
    tick();
    chk("bubble_flags", Flags, 4'b1001);
    drive(1'b0, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bubble_cxreg_hold", {3'b0, CondExReg}, 4'b0001);

    // Asynchronous reset between edges, pending write discarded
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_flags", Flags, 4'b0000);
    chk("async_rst_cxreg", {3'b0, CondExReg}, 4'b0000);
    tick();
    chk("rst_edge_flags", Flags, 4'b0000);
    reset_n = 1'b1;
    #1;
    chk("post_rst_flags", Flags, 4'b0000);
    tick();
    chk("first_edge_flags", Flags, 4'b1111);
    chk("first_edge_cxreg", {3'b0, CondExReg}, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/condlogic.md
CONDLOGIC -- requirements
Module: condlogic

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: current instruction valid; low = bubble/stall.
REQ-005 The block SHALL have port Cond, input, 4 bits: instruction condition field.
REQ-006 The block SHALL have port ALUFlags, input, 4 bits: ALU result flags {N,Z,C,V} of the current instruction.
REQ-007 The block SHALL have port FlagW, input, 2 bits: flag write request; bit1 = N,Z; bit0 = C,V.
REQ-008 The block SHALL have ports PCS, RegW, MemW, NoWrite, inputs, 1 bit each: decoder requests for PC write, register write, memory write, and destination-write suppression (CMP/CMN/TST/TEQ).
REQ-009 The block SHALL have ports PCSrc, RegWrite, MemWrite, outputs, 1 bit each: gated write enables.
REQ-010 The block SHALL have port CondEx, output, 1 bit: combinational condition result.
REQ-011 The block SHALL have port CondExReg, output, 1 bit: CondEx registered, for multicycle controllers.
REQ-012 The block SHALL have port Flags, output, 4 bits: stored flags {N,Z,C,V}.

Function
REQ-013 CondEx SHALL be evaluated from the stored Flags, never from ALUFlags, so an instruction sees the flags left by earlier instructions.
REQ-014 CondEx SHALL decode Cond as follows:
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C&~Z
- 1001 LS: ~C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: ~Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111 (reserved): 0
REQ-015 PCSrc SHALL equal PCS & CondEx & en.
REQ-016 RegWrite SHALL equal RegW & ~NoWrite & CondEx & en.
REQ-017 MemWrite SHALL equal MemW & CondEx & en.
REQ-018 On a rising clk edge with en & CondEx & FlagW[1], Flags[3:2] SHALL load ALUFlags[3:2]; otherwise they SHALL hold.
REQ-019 On a rising clk edge with en & CondEx & FlagW[0], Flags[1:0] SHALL load ALUFlags[1:0]; otherwise they SHALL hold.
REQ-020 The two flag halves SHALL update independently; FlagW=01 leaves N,Z untouched and FlagW=10 leaves C,V untouched.
REQ-021 A failed condition (CondEx=0) SHALL suppress all flag writes and all outputs in REQ-015..017 in the same cycle.
REQ-022 CondExReg SHALL load CondEx on every rising edge with en=1 and SHALL hold when en=0.
REQ-023 Flag updates SHALL have one-cycle latency: an instruction writing flags in cycle t affects CondEx from cycle t+1.
REQ-024 Flag update and condition evaluation in the same cycle SHALL use the pre-edge Flags value, with no bypass.
REQ-025 ALUFlags, FlagW, PCS, RegW, MemW and NoWrite SHALL have no effect while en=0.

Reset
REQ-026 While reset_n=0, Flags SHALL be 0000 and CondExReg SHALL be 0, asynchronously and regardless of clk.
REQ-027 Combinational outputs SHALL follow REQ-014..017 using Flags=0000 during and after reset.
REQ-028 A reset asserted mid-instruction SHALL discard any pending flag write, and the first edge after release SHALL behave as a normal cycle.

Verification
REQ-029 Bench SHALL cover: after reset, Cond=0000, PCS=1, en=1 -> CondEx=0, PCSrc=0; Cond=0001 -> CondEx=1, PCSrc=1.
REQ-030 Bench SHALL cover: CMP with Cond=1110, FlagW=11, ALUFlags=0110, RegW=1, NoWrite=1 -> RegWrite=0; next cycle Flags=0110 and EQ gives CondEx=1.
REQ-031 Bench SHALL cover: Flags=0110, then FlagW=01 with ALUFlags=1001 -> Flags=0101; then FlagW=10 with ALUFlags=1000 -> Flags=1001.
REQ-032 Bench SHALL cover: Flags=0100, Cond=0001 (NE fails), FlagW=11, MemW=1 -> MemWrite=0 and Flags stay 0100.
REQ-033 Bench SHALL cover: Flags=1000, checking GE/LT/GT/LE -> 0/1/0/1; Flags=1001 -> 1/0/1/0; Cond=1111 -> CondEx=0.
REQ-034 Bench SHALL cover: en=0 with FlagW=11, ALUFlags=1111, Cond=1110 -> outputs 0, Flags and CondExReg held; reset_n pulsed low between edges -> Flags=0000 immediately.
